// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet transmitter: line levels, state encoding
// and the packet checksum.
package uart_pkg;

  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t IDLE  = 3'd0;
  localparam uart_state_t START = 3'd1;
  localparam uart_state_t DATA  = 3'd2;
  localparam uart_state_t STOP  = 3'd3;
  localparam uart_state_t GAP   = 3'd4;

  // Two's-complement checksum: payload bytes plus this byte sum to zero mod 256.
  function automatic logic [7:0] chk8(input logic [7:0] sum);
    return (~sum) + 8'd1;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-frame UART serialiser: start bit, 8 data bits LSB first, STOP_BITS stop bits.
// A new byte is accepted in the last cycle of the last stop bit, so frames can abut.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_data_i,
  output logic       byte_ready_o,
  output logic       txd_o
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  uart_state_t       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [9:0]        shift_q, shift_d;
  logic              bit_end;
  logic              last_stop;

  assign bit_end      = (baud_q == BAUD_LAST);
  assign last_stop    = (state_q == STOP) && bit_end && (bit_q == STOP_LAST);
  assign byte_ready_o = (state_q == IDLE) || last_stop;
  // The line is the LSB of the shift register; it refills with idle-high ones.
  assign txd_o        = shift_q[0];

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 4'd0;
          shift_d = {UART_IDLE, shift_q[9:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {UART_IDLE, shift_q[9:1]};
          if (bit_q == 4'd7) begin
            state_d = STOP;
            bit_d   = 4'd0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: ;
    endcase

    if (byte_valid_i && byte_ready_o) begin
      state_d = START;
      baud_d  = '0;
      bit_d   = 4'd0;
      shift_d = {UART_IDLE, byte_data_i, UART_START};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 4'd0;
      shift_q <= '1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/uart_packet_tx.sv
// UART packet transmitter: latches up to MAX_BYTES payload bytes on start and sends them
// first-byte-first, optionally followed by a checksum byte, with optional inter-byte gaps.
module uart_packet_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned MAX_BYTES    = 16,
  parameter int unsigned LEN_W        = $clog2(MAX_BYTES + 1),
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned GAP_BITS     = 0,
  parameter int unsigned CHECKSUM_EN  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*MAX_BYTES-1:0] packet,
  input  logic [LEN_W-1:0]       length,
  input  logic                   start,
  output logic                   txd,
  output logic                   busy,
  output logic                   done,
  output logic                   err_len
);

  localparam int unsigned CNT_W   = LEN_W + 1;
  localparam int unsigned GAP_CYC = (GAP_BITS > 0) ? GAP_BITS * CLKS_PER_BIT : 2;
  localparam int unsigned GAP_W   = $clog2(GAP_CYC + 1);
  // Leave GAP one cycle early so START can present the byte on the final gap cycle.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 2);

  uart_state_t            state_q, state_d;
  logic [8*MAX_BYTES-1:0] pkt_q, pkt_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [CNT_W-1:0]       idx_q, idx_d;
  logic [7:0]             sum_q, sum_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic             len_ok;
  logic [CNT_W-1:0] n_bytes;
  logic [CNT_W-1:0] sel;
  logic             more;
  logic             is_payload;
  logic [7:0]       payload_byte;
  logic [7:0]       cur_byte;
  logic             byte_valid;
  logic             byte_ready;
  logic             handshake;

  assign len_ok     = (length != '0) && (32'(length) <= MAX_BYTES);
  assign n_bytes    = {1'b0, len_q} + CNT_W'(CHECKSUM_EN);
  assign more       = (idx_q < n_bytes);
  assign is_payload = (idx_q < {1'b0, len_q});
  assign sel        = {1'b0, len_q} - idx_q - CNT_W'(1);

  always_comb begin
    payload_byte = 8'h00;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (sel == CNT_W'(i)) begin
        payload_byte = pkt_q[8*i +: 8];
      end
    end
  end

  assign cur_byte   = is_payload ? payload_byte : chk8(sum_q);
  assign byte_valid = (state_q == START) ||
                      ((state_q == DATA) && more && (GAP_BITS == 0));
  assign handshake  = byte_valid && byte_ready;

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    gap_d   = gap_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (handshake) begin
      state_d = DATA;
      idx_d   = idx_q + CNT_W'(1);
      busy_d  = 1'b1;
      if (is_payload) begin
        sum_d = sum_q + cur_byte;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d = START;
            pkt_d   = packet;
            len_d   = length;
            idx_d   = '0;
            sum_d   = 8'h00;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DATA: begin
        // byte_ready here marks the last cycle of the frame on the line.
        if (byte_ready && !handshake) begin
          if (more) begin
            state_d = GAP;
            gap_d   = '0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = START;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= 8'h00;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .STOP_BITS    (STOP_BITS)
  ) u_byte_tx (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .byte_valid_i (byte_valid),
    .byte_data_i  (cur_byte),
    .byte_ready_o (byte_ready),
    .txd_o        (txd)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign err_len = err_q;

endmodule

// File: tb/tb_uart_packet_tx.sv
// Directed bench for uart_packet_tx: three configurations, per-cycle traces checked
// against hand-computed line bits, busy/done timing and error pulses.
module tb_uart_packet_tx;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] packet;
  logic [4:0]   length;
  int           sel;

  always #5 clk = ~clk;

  logic start_a, start_b, start_c;
  logic txd_a, busy_a, done_a, err_a;
  logic txd_b, busy_b, done_b, err_b;
  logic txd_c, busy_c, done_c, err_c;
  logic txd_s, busy_s, done_s, err_s;

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);

  assign txd_s  = (sel == 0) ? txd_a  : (sel == 1) ? txd_b  : txd_c;
  assign busy_s = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
  assign done_s = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
  assign err_s  = (sel == 0) ? err_a  : (sel == 1) ? err_b  : err_c;

  uart_packet_tx #(
    .CLKS_PER_BIT (4), .MAX_BYTES (16), .STOP_BITS (1), .GAP_BITS (0), .CHECKSUM_EN (1)
  ) u_a (
    .clk (clk), .rst_n (rst_n), .packet (packet), .length (length), .start (start_a),
    .txd (txd_a), .busy (busy_a), .done (done_a), .err_len (err_a)
  );

  uart_packet_tx #(
    .CLKS_PER_BIT (4), .MAX_BYTES (16), .STOP_BITS (2), .GAP_BITS (0), .CHECKSUM_EN (0)
  ) u_b (
    .clk (clk), .rst_n (rst_n), .packet (packet), .length (length), .start (start_b),
    .txd (txd_b), .busy (busy_b), .done (done_b), .err_len (err_b)
  );

  uart_packet_tx #(
    .CLKS_PER_BIT (4), .MAX_BYTES (16), .STOP_BITS (1), .GAP_BITS (2), .CHECKSUM_EN (0)
  ) u_c (
    .clk (clk), .rst_n (rst_n), .packet (packet), .length (length), .start (start_c),
    .txd (txd_c), .busy (busy_c), .done (done_c), .err_len (err_c)
  );

  // Index i holds values sampled just after edge i, edge 0 being the start edge.
  logic tx [0:511];
  logic bz [0:511];
  logic dn [0:511];
  logic er [0:511];

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic capture(input int n, input int poke_at, input int rst_at,
                         input logic [127:0] pk, input logic [4:0] ln);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      tx[i] = txd_s;
      bz[i] = busy_s;
      dn[i] = done_s;
      er[i] = err_s;
      start = (i + 1 == poke_at);
      if (i + 1 == poke_at) begin
        packet = pk;
        length = ln;
      end
      rst_n = (i + 1 != rst_at);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int cnt(input int kind, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) begin
      case (kind)
        0:       c += (tx[i] === 1'b1) ? 1 : 0;
        1:       c += (bz[i] === 1'b1) ? 1 : 0;
        2:       c += (dn[i] === 1'b1) ? 1 : 0;
        default: c += (er[i] === 1'b1) ? 1 : 0;
      endcase
    end
    return c;
  endfunction

  // Mid-bit samples of a 1-stop frame whose start bit begins at edge base.
  function automatic logic [9:0] frame(input int base);
    logic [9:0] f;
    for (int j = 0; j < 10; j++) f[j] = tx[base + 4*j + 2];
    return f;
  endfunction

  initial begin
    logic [10:0] seq;
    logic [7:0]  exp_b;
    int          ok;

    sel    = 0;
    start  = 1'b0;
    packet = '0;
    length = '0;
    rst_n  = 1'b0;
    idle(3);
    check("rst_txd_a", txd_a, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_err_a", err_a, 0);
    check("rst_txd_b", txd_b, 1);
    check("rst_txd_c", txd_c, 1);
    rst_n = 1'b1;
    idle(3);

    // "123456789" plus checksum 0x23
    sel    = 0;
    packet = 128'h31_32_33_34_35_36_37_38_39;
    length = 5'd9;
    start  = 1'b1;
    capture(420, -1, -1, '0, '0);
    check("t1_busy_edge0", bz[0], 0);
    check("t1_txd_edge1", tx[1], 0);
    check("t1_busy_edge1", bz[1], 1);
    check("t1_busy_cycles", cnt(1, 0, 419), 400);
    check("t1_done_edge401", dn[401], 1);
    check("t1_busy_edge401", bz[401], 0);
    check("t1_done_count", cnt(2, 0, 419), 1);
    for (int b = 0; b < 10; b++) begin
      exp_b = (b < 9) ? 8'(8'h31 + b) : 8'h23;
      check($sformatf("t1_byte%0d", b), frame(1 + 40*b), {1'b1, exp_b, 1'b0});
    end

    // 0xA5, 8N2, no checksum
    idle(5);
    sel    = 1;
    packet = 128'hA5;
    length = 5'd1;
    start  = 1'b1;
    capture(60, -1, -1, '0, '0);
    seq = {2'b11, 8'hA5, 1'b0};
    for (int k = 0; k < 11; k++) begin
      ok = 0;
      for (int m = 0; m < 4; m++) ok += (tx[1 + 4*k + m] === seq[k]) ? 1 : 0;
      check($sformatf("t2_bit%0d_cycles", k), ok, 4);
    end
    check("t2_busy_edge44", bz[44], 1);
    check("t2_done_edge45", dn[45], 1);
    check("t2_busy_edge45", bz[45], 0);
    check("t2_done_count", cnt(2, 0, 59), 1);

    // two bytes with a 2-bit gap
    idle(5);
    sel    = 2;
    packet = 128'h1234;
    length = 5'd2;
    start  = 1'b1;
    capture(110, -1, -1, '0, '0);
    check("t3_byte0", frame(1), {1'b1, 8'h12, 1'b0});
    check("t3_gap_high", cnt(0, 41, 48), 8);
    check("t3_second_start", tx[49], 0);
    check("t3_byte1", frame(49), {1'b1, 8'h34, 1'b0});
    check("t3_done_edge89", dn[89], 1);
    check("t3_busy_edge88", bz[88], 1);
    check("t3_done_count", cnt(2, 0, 109), 1);

    // illegal lengths
    idle(5);
    sel    = 0;
    length = 5'd0;
    start  = 1'b1;
    capture(10, -1, -1, '0, '0);
    check("t4_len0_err_edge0", er[0], 1);
    check("t4_len0_err_count", cnt(3, 0, 9), 1);
    check("t4_len0_txd_high", cnt(0, 0, 9), 10);
    check("t4_len0_busy", cnt(1, 0, 9), 0);
    idle(2);
    length = 5'd17;
    start  = 1'b1;
    capture(10, -1, -1, '0, '0);
    check("t4_len17_err_edge0", er[0], 1);
    check("t4_len17_err_count", cnt(3, 0, 9), 1);
    check("t4_len17_txd_high", cnt(0, 0, 9), 10);
    check("t4_len17_busy", cnt(1, 0, 9), 0);

    // re-start mid-packet with new data must be ignored
    idle(3);
    packet = 128'hABCD;
    length = 5'd2;
    start  = 1'b1;
    capture(200, 50, -1, 128'hFFFF, 5'd3);
    check("t5_byte0", frame(1), {1'b1, 8'hAB, 1'b0});
    check("t5_byte1", frame(41), {1'b1, 8'hCD, 1'b0});
    check("t5_chk", frame(81), {1'b1, 8'h88, 1'b0});
    check("t5_done_edge121", dn[121], 1);
    check("t5_done_count", cnt(2, 0, 199), 1);
    check("t5_busy_cycles", cnt(1, 0, 199), 120);

    // reset during a data bit, then a clean packet
    idle(3);
    packet = 128'h5A;
    length = 5'd1;
    start  = 1'b1;
    capture(20, -1, 10, '0, '0);
    check("t6_busy_before_rst", bz[9], 1);
    check("t6_txd_after_rst", tx[10], 1);
    check("t6_busy_after_rst", bz[10], 0);
    check("t6_no_done", cnt(2, 0, 19), 0);
    idle(3);
    start = 1'b1;
    capture(100, -1, -1, '0, '0);
    check("t6_byte0", frame(1), {1'b1, 8'h5A, 1'b0});
    check("t6_chk", frame(41), {1'b1, 8'hA6, 1'b0});
    check("t6_done_edge81", dn[81], 1);
    check("t6_done_count", cnt(2, 0, 99), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
